// File: rtl/dmx_pkg.sv
// Shared constants and state encoding for the DMX-512 frame sequencer.
package dmx_pkg;

  localparam int DMX_CH_MAX = 512;
  localparam int DMX_BRK_BIT = 8;
  localparam logic [7:0] DMX_DEFAULT_START = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    FETCH = 2'd2,
    SEND  = 2'd3
  } dmx_state_t;

endpackage

// File: rtl/dmx_chan_ram.sv
// Simple dual-port level store: one write port, one registered read port.
// The address MSB selects the bank, so both banks live in one array.
module dmx_chan_ram
  import dmx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmx_frame_sched.sv
// DMX-512 universe sequencer: double-buffered level store feeding the
// transmitter one byte per avail/ack handshake, one frame per refresh period.
module dmx_frame_sched
  import dmx_pkg::*;
#(
  parameter int CH_MAX   = DMX_CH_MAX,
  parameter int PERIOD_W = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [$clog2(CH_MAX):0]   cfg_channels,
  input  logic [7:0]                cfg_start_code,
  input  logic [PERIOD_W-1:0]       cfg_period,
  input  logic                      wr_en,
  input  logic [$clog2(CH_MAX)-1:0] wr_addr,
  input  logic [7:0]                wr_data,
  input  logic                      commit,
  output logic                      commit_pending,
  output logic                      tx_avail,
  output logic [8:0]                tx_data,
  input  logic                      tx_ack,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int CH_W = $clog2(CH_MAX);
  localparam logic [CH_W:0] CH_MAX_V = (CH_W+1)'(CH_MAX);

  dmx_state_t          state;
  logic [PERIOD_W-1:0] per_cnt;
  logic [PERIOD_W-1:0] period_m1;
  logic                frame_req;
  logic                front;
  logic [CH_W-1:0]     ch_idx;
  logic [CH_W-1:0]     last_idx;
  logic [CH_W-1:0]     rd_ch;
  logic [7:0]          rd_level;
  logic                ack;
  logic                tc;
  logic                last_ch;
  logic                start_frame;
  logic                rd_en;

  // Index of the last channel sent: 0 means one channel, oversize clamps.
  function automatic logic [CH_W-1:0] clamp_last(input logic [CH_W:0] n);
    if (n == '0)           return '0;
    else if (n > CH_MAX_V) return CH_W'(CH_MAX - 1);
    else                   return CH_W'(n - 1'b1);
  endfunction

  assign ack         = tx_ack & tx_avail;
  assign period_m1   = (cfg_period == '0) ? '0 : cfg_period - 1'b1;
  assign tc          = enable && (per_cnt >= period_m1);
  assign last_ch     = (ch_idx == last_idx);
  assign start_frame = (state == IDLE) && frame_req;
  assign rd_en       = ack && ((state == START) || ((state == SEND) && !last_ch));
  assign rd_ch       = (state == SEND) ? ch_idx + 1'b1 : ch_idx;

  // Reads always come from the front bank; writes always land in the back bank.
  dmx_chan_ram #(.DATA_W(8), .ADDR_W(CH_W + 1)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({~front, wr_addr}),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr ({front, rd_ch}),
    .rdata (rd_level)
  );

  // Refresh timer: a terminal count during a frame queues at most one request.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt   <= '0;
      frame_req <= 1'b0;
      overrun   <= 1'b0;
    end else if (!enable) begin
      per_cnt   <= '0;
      frame_req <= 1'b0;
    end else begin
      per_cnt <= tc ? '0 : per_cnt + 1'b1;
      if (tc)               frame_req <= 1'b1;
      else if (start_frame) frame_req <= 1'b0;
      if (tc && busy)       overrun   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      tx_avail       <= 1'b0;
      tx_data        <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      commit_pending <= 1'b0;
      front          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (commit) commit_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_req) begin
            // A commit arriving on the swap cycle stays pending for the next frame.
            if (commit_pending) begin
              front <= ~front;
              if (!commit) commit_pending <= 1'b0;
            end
            last_idx <= clamp_last(cfg_channels);
            ch_idx   <= '0;
            busy     <= 1'b1;
            tx_avail <= 1'b1;
            tx_data  <= {1'b1, cfg_start_code};
            state    <= START;
          end
        end
        START: begin
          if (ack) begin
            tx_avail <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          tx_data  <= {1'b0, rd_level};
          tx_avail <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (ack) begin
            tx_avail <= 1'b0;
            if (last_ch) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              ch_idx <= ch_idx + 1'b1;
              state  <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmx_frame_sched.sv
// Scoreboard bench for dmx_frame_sched: a transmitter model pops expected
// bytes as the sequencer offers them and acks after a programmable delay.
module tb_dmx_frame_sched;
  import dmx_pkg::*;

  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [9:0]    cfg_channels;
  logic [7:0]    cfg_start_code;
  logic [PW-1:0] cfg_period;
  logic          wr_en;
  logic [8:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          commit;
  logic          commit_pending;
  logic          tx_avail;
  logic [8:0]    tx_data;
  logic          tx_ack;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  always #5 clk = ~clk;

  dmx_frame_sched #(.CH_MAX(512), .PERIOD_W(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .cfg_channels   (cfg_channels),
    .cfg_start_code (cfg_start_code),
    .cfg_period     (cfg_period),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .commit         (commit),
    .commit_pending (commit_pending),
    .tx_avail       (tx_avail),
    .tx_data        (tx_data),
    .tx_ack         (tx_ack),
    .busy           (busy),
    .frame_done     (frame_done),
    .overrun        (overrun)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [7:0] mem_m [0:1023];
  logic       tb_front   = 1'b0;
  logic       tb_pending = 1'b0;
  int         ack_dly    = 5;
  int         acked      = 0;
  int         done_cnt   = 0;
  int         lat;
  int         base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = 9'(a);
    wr_data = d;
    mem_m[{~tb_front, 9'(a)}] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit     = 1'b1;
    tb_pending = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // Expected bytes for one frame, read from the bank that will be in front.
  task automatic push_frame(input int ch);
    int n;
    if (tb_pending) begin
      tb_front   = ~tb_front;
      tb_pending = 1'b0;
    end
    n = (ch == 0) ? 1 : ((ch > 512) ? 512 : ch);
    cfg_channels = 10'(ch);
    exp_q.push_back({1'b1, cfg_start_code});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, mem_m[{tb_front, 9'(i)}]});
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (!busy && n < 3000) begin
      tick();
      n++;
    end
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic start_frame(output int n);
    enable = 1'b1;
    wait_busy(n);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin
      tick();
      t++;
    end
    chk("frame_done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_acked(input int target);
    int t = 0;
    while (acked < target && t < 2000) begin
      tick();
      t++;
    end
    chk("ack_progress", 32'(acked >= target), 32'd1);
  endtask

  always @(negedge clk) if (frame_done) done_cnt++;

  // Transmitter model: compare on offer, hold for ack_dly cycles, then ack.
  initial begin : xmit
    logic       seen;
    logic       cur_valid;
    logic [8:0] cur_exp;
    int         wcnt;
    tx_ack    = 1'b0;
    seen      = 1'b0;
    cur_valid = 1'b0;
    cur_exp   = '0;
    wcnt      = 0;
    forever begin
      tick();
      if (!seen) begin
        if (tx_avail) begin
          seen = 1'b1;
          wcnt = 0;
          if (exp_q.size() == 0) begin
            cur_valid = 1'b0;
            chk("unexpected_tx_avail", 32'(tx_avail), 32'd0);
          end else begin
            cur_valid = 1'b1;
            cur_exp   = exp_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(cur_exp));
          end
        end
      end else begin
        wcnt++;
        if (wcnt >= ack_dly) begin
          if (cur_valid && tx_avail) chk("tx_hold", 32'(tx_data), 32'(cur_exp));
          tx_ack = 1'b1;
          tick();
          tx_ack = 1'b0;
          seen   = 1'b0;
          acked++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got %0d frames", done_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    cfg_channels   = 10'd3;
    cfg_start_code = DMX_DEFAULT_START;
    cfg_period     = PW'(20);
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    commit         = 1'b0;
    repeat (3) tick();
    chk("rst_tx_avail", 32'(tx_avail), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_commit_pending", 32'(commit_pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Three-channel frame from a freshly committed bank.
    for (int i = 0; i < 512; i++) wr(i, (i < 3) ? 8'(17 * (i + 1)) : 8'(i * 7 + 5));
    do_commit();
    chk("commit_pending_set", 32'(commit_pending), 32'd1);
    ack_dly = 5;
    push_frame(3);
    start_frame(lat);
    chk("first_frame_latency", 32'(lat), 32'd21);
    wait_done(1, 500);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("commit_pending_cleared", 32'(commit_pending), 32'd0);
    chk("queue_empty_1", 32'(exp_q.size()), 32'd0);

    // Channel count clamping: 0 -> 1 channel, 600 -> 512 channels.
    cfg_start_code = 8'h55;
    push_frame(0);
    start_frame(lat);
    wait_done(2, 500);
    ack_dly        = 1;
    cfg_start_code = 8'h00;
    push_frame(600);
    start_frame(lat);
    wait_done(3, 5000);
    chk("queue_empty_2", 32'(exp_q.size()), 32'd0);

    // Commit mid-frame: current frame keeps old levels, the next sends 0xAA.
    ack_dly = 3;
    for (int i = 0; i < 4; i++) wr(i, 8'hAA);
    push_frame(4);
    base = acked;
    start_frame(lat);
    wait_acked(base + 2);
    do_commit();
    chk("commit_mid_frame", 32'(commit_pending), 32'd1);
    wait_done(4, 500);
    chk("commit_held", 32'(commit_pending), 32'd1);
    push_frame(4);
    start_frame(lat);
    chk("commit_clr_at_start", 32'(commit_pending), 32'd0);
    wait_done(5, 500);
    chk("queue_empty_3", 32'(exp_q.size()), 32'd0);

    // enable dropped during channel 2 of 4: frame completes, nothing follows.
    cfg_period = PW'(200);
    ack_dly    = 5;
    push_frame(4);
    base   = acked;
    enable = 1'b1;
    wait_busy(lat);
    wait_acked(base + 2);
    enable = 1'b0;
    wait_done(6, 500);
    repeat (400) tick();
    chk("no_frame_after_disable", 32'(done_cnt), 32'd6);
    chk("queue_empty_5", 32'(exp_q.size()), 32'd0);
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // Overrun: slow acks stretch a frame past the period; one frame follows.
    cfg_period = PW'(100);
    ack_dly    = 30;
    push_frame(4);
    push_frame(4);
    enable = 1'b1;
    wait_busy(lat);
    lat = 0;
    while (!frame_done && lat < 600) begin
      tick();
      lat++;
    end
    chk("overrun_frame1_done", 32'(frame_done), 32'd1);
    tick();
    chk("b2b_tx_avail", 32'(tx_avail), 32'd1);
    chk("b2b_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    chk("overrun_set", 32'(overrun), 32'd1);
    wait_done(8, 1000);
    repeat (300) tick();
    chk("single_b2b_frame", 32'(done_cnt), 32'd8);
    chk("queue_empty_4", 32'(exp_q.size()), 32'd0);
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset while a channel byte is on offer aborts the frame at once.
    cfg_period = PW'(20);
    ack_dly    = 50;
    push_frame(4);
    enable = 1'b1;
    lat    = 0;
    while (!(tx_avail && !tx_data[8]) && lat < 500) begin
      tick();
      lat++;
    end
    chk("reached_send", 32'(tx_avail && !tx_data[8]), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_tx_avail", 32'(tx_avail), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    tb_front   = 1'b0;
    tb_pending = 1'b0;
    ack_dly    = 2;
    push_frame(4);
    rst = 1'b0;
    wait_busy(lat);
    chk("restart_latency", 32'(lat), 32'd21);
    enable = 1'b0;
    wait_done(9, 500);
    repeat (20) tick();
    chk("queue_empty_6", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmx_frame_sched.md
# dmx_frame_sched

DMX-512 universe sequencer that owns a double-buffered 512-channel level store and feeds the DMX transmitter one byte at a time over its avail/ack handshake. It emits a start code flagged for break, then the configured number of channel levels, then waits for the next refresh period. A host or pattern engine writes the back bank and commits it; banks swap only at frame boundaries, so no frame mixes old and new levels.

## Interface
- CH_MAX, 512: maximum channels per frame; sizes the address and counters.
- PERIOD_W, 24: width of the refresh-period counter.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  frame generation enabled.
- cfg_channels  in  10  channels per frame. 0 is treated as 1; values above CH_MAX are clamped to CH_MAX.
- cfg_start_code  in  8  DMX start code; normally 0x00.
- cfg_period  in  PERIOD_W  frame period in clk cycles; 0 is treated as 1.
- wr_en  in  1  back-bank write strobe.
- wr_addr  in  9  channel index, 0..511.
- wr_data  in  8  level.
- commit  in  1  one-cycle pulse; swap banks at the next frame start.
- commit_pending  out  1  commit accepted, swap not yet done.
- tx_avail  out  1  byte valid toward the transmitter.
- tx_data  out  9  bit 8 = precede the byte with break/MAB; bits 7:0 = byte.
- tx_ack  in  1  one-cycle pulse; the transmitter took tx_data.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last channel is acked.
- overrun  out  1  sticky; the period expired while busy. Cleared by rst only.

## Operation
- States: IDLE, START, FETCH, SEND.
- Period counter:
  - Runs while enable=1 and counts 0..cfg_period-1.
  - At terminal count it wraps and sets frame_req.
  - When enable=0 it is held at 0 and frame_req is cleared.
- IDLE: when frame_req=1:
  - Clear frame_req.
  - If commit_pending=1, swap the front bank and clear commit_pending.
  - Latch the clamped channel count; ch_idx<=0; busy<=1.
  - Go to START.
- START:
  - tx_avail=1, tx_data={1'b1, cfg_start_code}, with the start code sampled on START entry.
  - On tx_ack: drop tx_avail, issue a read of the front bank at ch_idx, go to FETCH.
- FETCH: RAM data returns. tx_data<={1'b0, level}, tx_avail<=1, go to SEND.
- SEND, on tx_ack:
  - If ch_idx==count-1: tx_avail<=0, busy<=0, pulse frame_done, go to IDLE.
  - Otherwise: ch_idx++, issue the next read, go to FETCH.
- tx_avail and tx_data stay stable until tx_ack. tx_ack while tx_avail=0 is ignored.
- Period expiry while busy=1 sets frame_req and overrun. The next frame then starts on the cycle after the return to IDLE. Multiple expiries queue only one request.
- enable deasserted mid-frame: the current frame finishes normally; no new frame starts.
- Write port:
  - wr_en writes the back bank (not front) every cycle, regardless of state.
  - commit sets commit_pending.
  - commit in the same cycle as the swap is held pending for the following frame.
  - After a swap, the new back bank holds stale data; the writer owns a full rewrite.

## Timing
- Reset values: tx_avail=0, tx_data=0, busy=0, frame_done=0, commit_pending=0, overrun=0, front bank=0, period counter=0, state IDLE. RAM contents are not reset.
- Reset mid-frame aborts immediately. The transmitter finishes its current byte and then sees tx_avail=0.
- First frame: frame_req is set cycle_period cycles after enable rises. START drives tx_avail on the next edge.
- tx_ack to next tx_avail: 2 edges (FETCH, then SEND). This is well inside one DMX bit time.
- RAM read latency is 1 cycle, registered output.
- A frame of N channels takes N+1 acks. frame_done is asserted in the cycle after the last ack.

## Structure
- Package dmx_pkg holds:
  - DMX_CH_MAX=512.
  - The state enum {IDLE, START, FETCH, SEND}.
  - DMX_BRK_BIT=8.
  - DMX_DEFAULT_START=8'h00.
- Sub-module dmx_chan_ram: 1024x8 simple dual-port RAM with one write port and one registered read port. The address is {bank, ch}; the controller supplies the bank bit.

## Test plan
- cfg_channels=3, start=0x00, levels 0x11/0x22/0x33, tx_ack 5 cycles after each tx_avail -> tx_data sequence 0x100, 0x011, 0x022, 0x033; then frame_done, busy=0.
- cfg_channels=0 and then 600 -> frames contain 1 and 512 channels respectively; the last channel read is index 511.
- Write bank to 0xAA, commit mid-frame -> the current frame keeps the old levels; the next frame sends 0xAA; commit_pending clears at its START.
- cfg_period=100 with slow acks so a frame exceeds 100 cycles -> overrun=1; exactly one back-to-back frame follows.
- enable dropped during channel 2 of 4 -> channels 3 and 4 are still sent, then no further tx_avail.
- rst asserted in SEND -> next cycle tx_avail=0, busy=0, state IDLE; the counter restarts from 0 after rst.
